// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed common-anode 7-segment scanner.
// Keeps a frame-aligned shadow of the digit codes so a frame never mixes
// two loads, blanks a guard band at the start of each slot to stop ghosting,
// and layers leading-zero blanking and per-digit blinking over the decode.
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 6,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [4*NUM_DIGITS-1:0]       digits_in,
    input  logic [NUM_DIGITS-1:0]         blink_mask,
    input  logic                          load,
    input  logic                          lzb_en,
    output logic [6:0]                    seg_n,
    output logic [NUM_DIGITS-1:0]         an_n,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FRM_LAST  = FW'(BLINK_FRAMES - 1);

    // One display image: four-bit code per digit plus its blink enable.
    typedef struct packed {
        logic [NUM_DIGITS-1:0][3:0] dig;
        logic [NUM_DIGITS-1:0]      blink;
    } shadow_t;

    // Reset image shows every digit as code 0xF (off), no blinking.
    localparam shadow_t SHADOW_RST =
        shadow_t'({{(4*NUM_DIGITS){1'b1}}, {NUM_DIGITS{1'b0}}});

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [FW-1:0]         frm_q, frm_d;
    logic                  phase_q, phase_d;
    shadow_t               act_q, act_d, pend_q, pend_d, in_s;
    logic                  pflag_q, pflag_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [IW-1:0]         didx_q;
    logic                  fd_q;

    logic                  slot_end, frame_end;
    logic [NUM_DIGITS-1:0] lzb_blank;
    logic                  above_zero;
    logic [3:0]            nib;

    function automatic logic [6:0] decode(input logic [3:0] c);
        case (c)
            4'h0:    decode = 7'b0000001;
            4'h1:    decode = 7'b1001111;
            4'h2:    decode = 7'b0010010;
            4'h3:    decode = 7'b0000110;
            4'h4:    decode = 7'b1001100;
            4'h5:    decode = 7'b0100100;
            4'h6:    decode = 7'b0100000;
            4'h7:    decode = 7'b0001111;
            4'h8:    decode = 7'b0000000;
            4'h9:    decode = 7'b0000100;
            4'hA:    decode = 7'b0001000;
            4'hB:    decode = 7'b0011000;
            4'hC:    decode = 7'b1111110;
            4'hF:    decode = 7'b1111111;
            default: decode = 7'b0110110;
        endcase
    endfunction

    // Slot/digit scan counters and the blink frame counter.
    always_comb begin
        slot_end  = (cnt_q == CNT_LAST);
        frame_end = slot_end && (idx_q == IDX_LAST);
        cnt_d     = slot_end ? '0 : cnt_q + CW'(1);
        idx_d     = idx_q;
        frm_d     = frm_q;
        phase_d   = phase_q;
        if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        if (frame_end) begin
            if (frm_q == FRM_LAST) begin
                frm_d   = '0;
                phase_d = ~phase_q;
            end else begin
                frm_d = frm_q + FW'(1);
            end
        end
    end

    // Shadow update: loads park in pending and only reach active at frame end;
    // a load coinciding with frame end bypasses pending entirely.
    always_comb begin
        in_s.dig   = digits_in;
        in_s.blink = blink_mask;
        act_d      = act_q;
        pend_d     = pend_q;
        pflag_d    = pflag_q;
        if (frame_end) begin
            if (load)         act_d = in_s;
            else if (pflag_q) act_d = pend_q;
            pflag_d = 1'b0;
        end else if (load) begin
            pend_d  = in_s;
            pflag_d = 1'b1;
        end
    end

    // Leading-zero mask: a digit is blankable when it and everything above it is 0.
    always_comb begin
        lzb_blank  = '0;
        above_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (act_q.dig[i] != 4'h0) above_zero = 1'b0;
            if (above_zero) lzb_blank[i] = 1'b1;
        end
    end

    // Next output image: dark in the guard band, else decode with overrides.
    always_comb begin
        nib  = act_q.dig[idx_q];
        seg_d = 7'h7F;
        an_d  = '1;
        if (cnt_q >= BLANK_END) begin
            an_d[idx_q] = 1'b0;
            seg_d       = decode(nib);
            if (lzb_en && lzb_blank[idx_q])    seg_d = 7'h7F;
            if (act_q.blink[idx_q] && phase_q) seg_d = 7'h7F;
        end
    end

    // State and registered outputs; reset blanks the display immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            frm_q   <= '0;
            phase_q <= 1'b0;
            act_q   <= SHADOW_RST;
            pend_q  <= SHADOW_RST;
            pflag_q <= 1'b0;
            seg_q   <= 7'h7F;
            an_q    <= '1;
            didx_q  <= '0;
            fd_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            frm_q   <= frm_d;
            phase_q <= phase_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            pflag_q <= pflag_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            didx_q  <= idx_q;
            fd_q    <= frame_end;
        end
    end

    assign seg_n      = seg_q;
    assign an_n       = an_q;
    assign digit_idx  = didx_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: cycle scoreboard plus directed table/sequence checks.
module tb_seg7_scan_driver;

    localparam int ND = 4, SD = 8, BC = 2, BF = 2, FRAME = ND * SD;

    typedef struct {logic [3:0] code; logic [6:0] seg;} dec_vec_t;
    typedef struct {logic lzb; logic [15:0] dig; logic [6:0] seg [4];} lzb_vec_t;
    typedef struct {logic [6:0] seg; logic [3:0] an; logic [1:0] idx; logic fd;} exp_t;

    logic        clk = 1'b0, rst_n = 1'b1, load = 1'b0, lzb_en = 1'b0;
    logic [15:0] digits_in = 16'hFFFF;
    logic [3:0]  blink_mask = 4'h0;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int n_cmp = 0, n_bad = 0;
    dec_vec_t dtab [16];
    lzb_vec_t ltab [4];
    exp_t     sbq[$];

    // reference model state
    int          m_cnt = 0, m_idx = 0, m_frm = 0;
    logic        m_phase = 0, m_pflag = 0;
    logic [15:0] m_act = 16'hFFFF, m_pend = 16'hFFFF;
    logic [3:0]  m_ab = 0, m_pb = 0;

    // per-frame capture
    logic [6:0] cap_seg [4];
    int cap_lit [4];
    int cap_nz, cap_fd, cap_multi;

    seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .blink_mask(blink_mask),
        .load(load), .lzb_en(lzb_en), .seg_n(seg_n), .an_n(an_n),
        .digit_idx(digit_idx), .frame_done(frame_done));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] dec(input logic [3:0] c);
        return dtab[c].seg;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int h;
        e.seg = 7'h7F; e.an = 4'hF; e.idx = 2'(m_idx);
        e.fd  = (m_cnt == SD - 1) && (m_idx == ND - 1);
        if (m_cnt >= BC) begin
            e.an[m_idx] = 1'b0;
            e.seg = dec(m_act[m_idx*4 +: 4]);
            h = -1;
            for (int i = 0; i < ND; i++) if (m_act[i*4 +: 4] != 4'h0) h = i;
            if (lzb_en && m_idx > h && m_idx != 0) e.seg = 7'h7F;
            if (m_ab[m_idx] && m_phase) e.seg = 7'h7F;
        end
        return e;
    endfunction

    task automatic model_step();
        bit fe = (m_cnt == SD - 1) && (m_idx == ND - 1);
        if (fe) begin
            if (load) begin m_act = digits_in; m_ab = blink_mask; end
            else if (m_pflag) begin m_act = m_pend; m_ab = m_pb; end
            m_pflag = 0;
            m_frm++;
            if (m_frm == BF) begin m_frm = 0; m_phase = !m_phase; end
        end else if (load) begin
            m_pend = digits_in; m_pb = blink_mask; m_pflag = 1;
        end
        if (m_cnt == SD - 1) begin m_cnt = 0; m_idx = (m_idx + 1) % ND; end
        else m_cnt++;
    endtask

    task automatic model_reset();
        m_cnt = 0; m_idx = 0; m_frm = 0; m_phase = 0; m_pflag = 0;
        m_act = 16'hFFFF; m_pend = 16'hFFFF; m_ab = 0; m_pb = 0;
        sbq.delete();
    endtask

    task automatic wait_fd();
        int t = 0;
        do begin @(negedge clk); t++; end while (!frame_done && t < 200);
        if (!frame_done) chk("fd_timeout", frame_done, 1);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] m);
        digits_in = d; blink_mask = m; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic capture_frame();
        int lows;
        for (int d = 0; d < 4; d++) begin cap_seg[d] = 7'h55; cap_lit[d] = 0; end
        cap_nz = 0; cap_fd = 0; cap_multi = 0;
        repeat (FRAME) begin
            @(negedge clk);
            lows = $countones(~an_n);
            if (lows > 1) cap_multi++;
            for (int d = 0; d < 4; d++)
                if (lows == 1 && an_n[d] == 1'b0) begin cap_lit[d]++; cap_seg[d] = seg_n; end
            if (seg_n != 7'h7F) cap_nz++;
            if (frame_done) cap_fd++;
        end
    endtask

    task automatic load_and_show(input logic [15:0] d, input logic [3:0] m);
        wait_fd();
        do_load(d, m);
        wait_fd();
        capture_frame();
    endtask

    initial begin
        bit bl [8];
        int fdc, ons;
        exp_t e;
        dtab[0]  = '{4'h0, 7'b0000001}; dtab[1]  = '{4'h1, 7'b1001111};
        dtab[2]  = '{4'h2, 7'b0010010}; dtab[3]  = '{4'h3, 7'b0000110};
        dtab[4]  = '{4'h4, 7'b1001100}; dtab[5]  = '{4'h5, 7'b0100100};
        dtab[6]  = '{4'h6, 7'b0100000}; dtab[7]  = '{4'h7, 7'b0001111};
        dtab[8]  = '{4'h8, 7'b0000000}; dtab[9]  = '{4'h9, 7'b0000100};
        dtab[10] = '{4'hA, 7'b0001000}; dtab[11] = '{4'hB, 7'b0011000};
        dtab[12] = '{4'hC, 7'b1111110}; dtab[13] = '{4'hD, 7'b0110110};
        dtab[14] = '{4'hE, 7'b0110110}; dtab[15] = '{4'hF, 7'b1111111};
        // seg[] index = digit number
        ltab[0] = '{1'b1, 16'h0012, '{7'b0010010, 7'b1001111, 7'h7F, 7'h7F}};
        ltab[1] = '{1'b1, 16'h0000, '{7'b0000001, 7'h7F, 7'h7F, 7'h7F}};
        ltab[2] = '{1'b1, 16'h0F02, '{7'b0010010, 7'b0000001, 7'h7F, 7'h7F}};
        ltab[3] = '{1'b0, 16'h0012, '{7'b0010010, 7'b1001111, 7'b0000001, 7'b0000001}};

        fork
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) model_reset();
                else begin sbq.push_back(model_out()); model_step(); end
            end
            forever begin
                @(negedge clk);
                if (rst_n && sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("sb", {seg_n, an_n, digit_idx, frame_done}, {e.seg, e.an, e.idx, e.fd});
                end
            end
        join_none

        // reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_seg", seg_n, 7'h7F); chk("rst_an", an_n, 4'hF);
        chk("rst_fd", frame_done, 0); chk("rst_idx", digit_idx, 0);
        repeat (3) @(negedge clk);
        chk("rst_hold_an", an_n, 4'hF);
        rst_n = 1'b1;

        // idle: nothing loaded, display dark, each anode low 6 of 8 cycles
        wait_fd();
        capture_frame();
        chk("idle_nz", cap_nz, 0); chk("idle_fd", cap_fd, 1); chk("idle_multi", cap_multi, 0);
        for (int d = 0; d < 4; d++) chk($sformatf("idle_lit%0d", d), cap_lit[d], 6);

        // decode sweep on digit 0
        for (int i = 0; i < 16; i++) begin
            load_and_show({12'hFFF, dtab[i].code}, 4'h0);
            chk($sformatf("dec_%0h", i), cap_seg[0], dtab[i].seg);
        end

        // tear-free load: two loads mid-frame, only the last shows next frame
        load_and_show(16'h9999, 4'h0);
        repeat (20) @(negedge clk);
        do_load(16'h1234, 4'h0);
        chk("tear_s2_an", an_n, 4'b1011); chk("tear_s2_seg", seg_n, dec(4'h9));
        repeat (7) @(negedge clk);
        do_load(16'h5678, 4'h0);
        chk("tear_s3_an", an_n, 4'b0111); chk("tear_s3_seg", seg_n, dec(4'h9));
        repeat (3) @(negedge clk);
        chk("tear_fd", frame_done, 1);
        capture_frame();
        chk("tear_d3", cap_seg[3], dec(4'h5)); chk("tear_d2", cap_seg[2], dec(4'h6));
        chk("tear_d1", cap_seg[1], dec(4'h7)); chk("tear_d0", cap_seg[0], dec(4'h8));

        // blink digit 0: 2 frames lit / 2 frames dark, anode still driven
        wait_fd();
        do_load(16'h1234, 4'b0001);
        wait_fd();
        ons = 0;
        for (int f = 0; f < 8; f++) begin
            capture_frame();
            bl[f] = (cap_seg[0] == 7'h7F);
            if (bl[f]) ons++;
            chk("blink_an0", cap_lit[0], 6);
            chk("blink_d1", cap_seg[1], dec(4'h3));
            if (!bl[f]) chk("blink_d0_lit", cap_seg[0], dec(4'h4));
        end
        chk("blink_count", ons, 4);
        for (int f = 0; f < 6; f++) chk($sformatf("blink_per%0d", f), bl[f] ^ bl[f+2], 1);
        load_and_show(16'h1234, 4'h0);

        // leading-zero blanking vectors
        for (int v = 0; v < 4; v++) begin
            lzb_en = ltab[v].lzb;
            load_and_show(ltab[v].dig, 4'h0);
            for (int d = 0; d < 4; d++)
                chk($sformatf("lzb%0d_d%0d", v, d), cap_seg[d], ltab[v].seg[d]);
        end
        lzb_en = 1'b0;

        // reset mid-frame with a pending load: async blank, load discarded
        wait_fd();
        do_load(16'h4321, 4'h0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_seg", seg_n, 7'h7F); chk("mid_rst_an", an_n, 4'hF);
        chk("mid_rst_fd", frame_done, 0); chk("mid_rst_idx", digit_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); chk("rel_c1_an", an_n, 4'hF);
        @(negedge clk); chk("rel_c2_an", an_n, 4'hF);
        @(negedge clk); chk("rel_first_lit", an_n, 4'b1110); chk("rel_first_seg", seg_n, 7'h7F);
        fdc = 0;
        repeat (FRAME - 4) begin @(negedge clk); if (frame_done) fdc++; end
        chk("no_early_fd", fdc, 0);
        @(negedge clk); chk("first_fd", frame_done, 1);
        capture_frame(); chk("rel_dark0", cap_nz, 0);
        capture_frame(); chk("rel_dark1", cap_nz, 0);
        load_and_show(16'h5678, 4'h0);
        chk("recover_d0", cap_seg[0], dec(4'h8));
        chk("recover_d3", cap_seg[3], dec(4'h5));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for a parametrised bank of common-anode seven-segment digits. It holds a tear-free shadow copy of the digit codes and scans one digit per slot with a ghosting guard band. It also adds per-digit blinking and optional leading-zero blanking. It sits between the clock/calendar datapath, which supplies 4-bit codes per digit, and the board's segment and anode pins.

## Interface
Parameters:
- NUM_DIGITS, 6: number of digits scanned; legal range 2..16.
- SCAN_DIV, 1000: clocks per digit slot; must be at least 2.
- BLANK_CYCLES, 16: guard cycles at the start of each slot; legal range is 1 to SCAN_DIV-1.
- BLINK_FRAMES, 250: full frames per blink half-period; must be at least 1.

Ports:
- clk, in, 1: the single clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- digits_in, in, 4*NUM_DIGITS: digit codes; nibble i drives digit i, and digit 0 is the least significant.
- blink_mask, in, NUM_DIGITS: a 1 makes that digit blink.
- load, in, 1: captures digits_in and blink_mask.
- lzb_en, in, 1: enables leading-zero blanking.
- seg_n, out, 7: segments {a,b,c,d,e,f,g}, active-low, registered.
- an_n, out, NUM_DIGITS: digit enables, active-low, one-hot-low or all-high, registered.
- digit_idx, out, clog2(NUM_DIGITS): index of the digit currently driven, registered.
- frame_done, out, 1: one-cycle pulse after the last slot of each frame.

## Operation
Code decode (seg_n = abcdefg, 0 means lit):
- 0: 0000001
- 1: 1001111
- 2: 0010010
- 3: 0000110
- 4: 1001100
- 5: 0100100
- 6: 0100000
- 7: 0001111
- 8: 0000000
- 9: 0000100
- A (code 0xA): 0001000
- P (code 0xB): 0011000
- "-" (code 0xC): 1111110
- off (code 0xF): 1111111
- 0xD and 0xE: 0110110

Scan:
- slot counter cnt runs 0..SCAN_DIV-1; on wrap, idx advances 0→1→…→NUM_DIGITS-1→0.
- When cnt < BLANK_CYCLES, the driven state is seg_n = 7F and an_n = all ones.
- Otherwise an_n[idx] = 0 and seg_n = decode(active nibble idx), subject to the overrides below.

Overrides, in order:
- Leading-zero blanking: when lzb_en = 1, every digit above the highest nonzero nibble with value 0 is forced off. Digit 0 is never blanked. Code 0xF counts as nonzero for this scan.
- Blink: when blink_mask_active[idx] = 1 and phase = 1, seg_n = 7F. The anode is still enabled.

Shadow registers:
- load=1 captures into pending and sets a pending flag.
- At the frame-end edge (cnt = SCAN_DIV-1, idx = NUM_DIGITS-1), pending is copied to active and the flag is cleared.
- load in the same cycle as frame end: the new digits_in and blink_mask go directly to active, and the flag is left clear.
- Multiple loads within a frame: the last one wins.
- active never changes mid-frame.

Blink:
- frame counter runs 0..BLINK_FRAMES-1 and increments at each frame end.
- phase toggles when the frame counter wraps.

## Timing
- All outputs are registered. The outputs during cycle k+1 reflect the cnt, idx, active and phase values held in cycle k. Latency is 1 clock.
- frame_done is high for exactly the one cycle in which cnt = 0 and idx = 0 after a wrap. It is never high after reset before the first wrap.
- Anode hand-off: the previous digit's an_n bit rises on the same edge on which the guard band starts. No two an_n bits are ever low in the same cycle.
- Reset values (rst_n low, asynchronous):
  - cnt, idx, frame counter, phase, digit_idx: 0
  - active digits: all 0xF; active and pending blink_mask: 0; pending flag: 0
  - seg_n = 7F, an_n = all ones, frame_done = 0
- Reset asserted mid-slot or mid-frame immediately blanks the display and discards any pending load.
- After rst_n deasserts, the first lit cycle is clock BLANK_CYCLES+1, on digit 0.

## Test plan
- Reset and idle (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2), no load: seg_n stays 7F in every cycle. an_n cycles through 1110, 1101, 1011, 0111, each low for 6 of 8 cycles. frame_done pulses every 32 cycles.
- Decode sweep: load nibbles 0..F, one value per frame, and sample digit 0. Each code must produce its table value; 0xD and 0xE must give 0110110.
- Tear-free load: load 0x1234 mid-way through slot 2, then load 0x5678 in slot 3. Slots 2 and 3 of the current frame still show the old values. The next frame shows 5,6,7,8 on digits 3..0, and 0x1234 is never displayed.
- Blink (BLINK_FRAMES=2, blink_mask=0001): digit 0 is lit for 2 frames, shows 7F with its anode low for 2 frames, and repeats. The other digits are lit continuously.
- Leading-zero blanking with lzb_en=1: digits 0x0012 show off, off, 1, 2. Digits 0x0000 show off, off, off, 0. Digits 0x0F02 show off, off (code F), 0, 2. With lzb_en=0, 0x0012 shows 0, 0, 1, 2.
- Reset mid-frame with a load pending: outputs return to their reset values asynchronously. After release, the display stays off until a new load is committed.
